mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Multi-cycle sequencer for the shared combinational RV64M multiply/divide unit (`mac`) in the EXU. It accepts one M-extension operation at a time over a valid/ready handshake and drives `mac` with registered operands and a one-hot op select. It holds the operation for a configurable number of cycles so the combinational result settles (multicycle path), then returns the result. The controller handles RV64 W-variants, divide-by-zero and signed-overflow in-house, so `mac` never sees an undefined division.

## Interface
- `MUL_LAT`, default 3: CALC cycles for mul/mulh/mulhsu/mulhu; must be ≥1.
- `DIV_LAT`, default 16: CALC cycles for div/divu/rem/remu; must be ≥1.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  controller can accept a request.
- `in_op`  in  3  funct3: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
- `in_word`  in  1  W-variant: mulw/divw/divuw/remw/remuw. Ignored for ops 1–3.
- `in_src1`, `in_src2`  in  64  operands.
- `in_tag`  in  5  destination register tag, returned unchanged.
- `flush`  in  1  pipeline flush.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_result`  out  64  final result.
- `out_tag`  out  5  tag of the result.
- `mac_op`  out  8  one-hot to `mac`: bit 7 mul, 6 mulh, 5 mulhu, 4 mulhsu, 3 div, 2 divu, 1 rem, 0 remu.
- `mac_src1`, `mac_src2`  out  64  registered operands to `mac`.
- `mac_result`  in  64  combinational result from `mac`.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States:
  - IDLE: `in_ready` = !`flush`.
  - CALC: `mac_op` asserted, down-counter running.
  - DONE: `out_valid` = 1.
- IDLE → CALC on `in_valid && in_ready`:
  - Operand capture, W mode: signed ops (div, rem, mul) sign-extend `[31:0]`; divu/remu zero-extend `[31:0]`.
  - Non-W mode: operands are captured unchanged.
  - Counter loads LAT−1.
  - Tag and op are latched.
- CALC:
  - Counter decrements each cycle.
  - On the cycle the counter = 0, `out_result` is captured and the state moves to DONE.
  - If W: `out_result` = sign-extend(`mac_result[31:0]`).
  - Otherwise: `out_result` = `mac_result`.
- DONE → IDLE on `out_ready`. `out_result`/`out_tag` stay stable while `out_valid && !out_ready`.
- Special cases are detected at accept, using the 32-bit view in W mode:
  - Divisor = 0: div/divu → all ones (W: 0xFFFFFFFF_FFFFFFFF); rem/remu → dividend (W: sign-extended low 32).
  - Signed overflow (src1 = most-negative, src2 = −1): div → src1; rem → 0.
  - In a special case `mac_op` stays 0 and `mac_src*` are not updated. The result comes from the special value, not `mac_result`.
- `mac_op` is zero outside CALC. It is always one-hot or zero.
- `flush` in any state: IDLE on the next edge, pending result discarded, `out_valid` deasserts. A flush in DONE concurrent with `out_ready` is still a discard; the consumer must ignore it.
- Reset, asynchronous, from any state, including mid-CALC:
  - State goes to IDLE.
  - `out_valid`, `busy`, `mac_op`, `mac_src1`, `mac_src2`, `out_result`, `out_tag` and the counter all go to 0.
  - `in_ready` = 1 after reset release.

## Timing
- Request accepted at edge k.
- `mac_op` is high during cycles k+1 … k+LAT.
- `out_valid` rises after edge k+LAT+1. Accept-to-valid latency is LAT+1 cycles.
- Single outstanding op; `in_ready` is low from k+1 until DONE completes.
- Minimum issue interval is LAT+2 cycles with `out_ready` held high.
- `mac_src*` are stable for the whole of CALC; `mac` paths are multicycle by LAT.
- `out_ready` low stalls DONE indefinitely with no state change.

## Configuration
- `MDU_FAST_SPECIAL_EN`:
  - Defined: special cases go IDLE → DONE directly, with `out_valid` after edge k+1 (latency 1).
  - Undefined: special cases still pass through CALC for the full LAT cycles, with `mac_op` = 0, and give the same result at LAT+1.
  - Result values are identical in both builds.

## Test plan
- mul, src1 = 3, src2 = −4, MUL_LAT = 3 → `mac_op` = 0x80 for 3 cycles; `out_valid` at +4; `out_result` = 0xFFFFFFFF_FFFFFFF4.
- divu, src2 = 0, src1 = 7 → `out_result` = 0xFFFFFFFF_FFFFFFFF. `mac_op` never nonzero. Latency 1 with `MDU_FAST_SPECIAL_EN`, 17 without.
- divw, src1 = 0x00000000_80000000, src2 = 0xFFFFFFFF → `out_result` = 0xFFFFFFFF_80000000; remw on the same operands → 0.
- mulhu, both all ones → 0xFFFFFFFF_FFFFFFFE. Hold `out_ready` = 0 for 5 cycles: `out_valid`/`out_result` stay stable and `in_ready` stays 0.
- div issued, `flush` asserted at CALC cycle 5 → IDLE next edge, no `out_valid`. A new mul is accepted on the following cycle and completes correctly.
- `reset` pulsed mid-CALC of a rem → all outputs 0 immediately, `in_ready` = 1 after release, no stale result.

Source files
------------

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle sequencer for the shared combinational RV64M mul/div unit.
// Holds registered operands and a one-hot op select for MUL_LAT/DIV_LAT cycles,
// then captures the settled result. Divide-by-zero and signed overflow are
// resolved locally so the arithmetic unit never sees an undefined division.
// Optional build macro: MDU_FAST_SPECIAL_EN -- special-case results skip CALC
// and are presented one cycle after accept.
module mdu_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic        in_word,
    input  logic [63:0] in_src1,
    input  logic [63:0] in_src2,
    input  logic [4:0]  in_tag,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic [4:0]  out_tag,
    output logic [7:0]  mac_op,
    output logic [63:0] mac_src1,
    output logic [63:0] mac_src2,
    input  logic [63:0] mac_result,
    output logic        busy
);

`ifdef MDU_FAST_SPECIAL_EN
    localparam bit FAST_SPECIAL = 1'b1;
`else
    localparam bit FAST_SPECIAL = 1'b0;
`endif

    localparam int LMAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW   = $clog2(LMAX + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [2:0]    op_q;
    logic          word_q, special_q;

    logic          is_div, word, zext, accept;
    logic          div_zero, div_ovf, special;
    logic [63:0]   op_a, op_b, spec_val, res_w;
    logic [CW-1:0] lat_load;

    // Accept-time decode: W-mode operand extension and special-case detection
    always_comb begin
        is_div = in_op[2];
        word   = in_word && (in_op == 3'd0 || is_div);
        zext   = word && is_div && in_op[0];
        op_a   = in_src1;
        op_b   = in_src2;
        if (word) begin
            op_a = zext ? {32'd0, in_src1[31:0]} : {{32{in_src1[31]}}, in_src1[31:0]};
            op_b = zext ? {32'd0, in_src2[31:0]} : {{32{in_src2[31]}}, in_src2[31:0]};
        end
        // In W mode the extended operands make these 64-bit compares equal the 32-bit view
        div_zero = is_div && (op_b == 64'd0);
        div_ovf  = is_div && !in_op[0] && (op_b == '1) &&
                   (op_a == (word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        special  = div_zero || div_ovf;
        spec_val = '1;
        if (div_zero) begin
            if (in_op[1])
                spec_val = word ? {{32{in_src1[31]}}, in_src1[31:0]} : in_src1;
        end else if (div_ovf) begin
            spec_val = in_op[1] ? 64'd0 : op_a;
        end
        lat_load = is_div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
        in_ready = (state == IDLE) && !flush;
        accept   = in_ready && in_valid;
        res_w    = word_q ? {{32{mac_result[31]}}, mac_result[31:0]} : mac_result;
    end

    // Status outputs and the one-hot select, live only during a real CALC
    always_comb begin
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        mac_op    = 8'd0;
        if (state == CALC && !special_q) begin
            case (op_q)
                3'd0:    mac_op = 8'h80;
                3'd1:    mac_op = 8'h40;
                3'd2:    mac_op = 8'h10;
                3'd3:    mac_op = 8'h20;
                3'd4:    mac_op = 8'h08;
                3'd5:    mac_op = 8'h04;
                3'd6:    mac_op = 8'h02;
                default: mac_op = 8'h01;
            endcase
        end
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = (FAST_SPECIAL && special) ? DONE : CALC;
            CALC: if (cnt == '0) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Operand/result capture and latency down-counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            op_q       <= 3'd0;
            word_q     <= 1'b0;
            special_q  <= 1'b0;
            mac_src1   <= 64'd0;
            mac_src2   <= 64'd0;
            out_result <= 64'd0;
            out_tag    <= 5'd0;
        end else if (accept) begin
            cnt       <= lat_load;
            op_q      <= in_op;
            word_q    <= word;
            special_q <= special;
            out_tag   <= in_tag;
            if (special) begin
                out_result <= spec_val;
            end else begin
                mac_src1 <= op_a;
                mac_src2 <= op_b;
            end
        end else if (state == CALC) begin
            if (cnt != '0)
                cnt <= cnt - CW'(1);
            else if (!special_q)
                out_result <= res_w;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus randomized ops against
// an RV64M arithmetic reference and a transaction-level timing model.
module tb_mdu_ctrl;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 16;
`ifdef MDU_FAST_SPECIAL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clock, reset, in_valid, in_ready, in_word, flush;
    logic        out_valid, out_ready, busy;
    logic [2:0]  in_op;
    logic [63:0] in_src1, in_src2, out_result, mac_src1, mac_src2, mac_result;
    logic [4:0]  in_tag, out_tag;
    logic [7:0]  mac_op;

    int n_chk = 0;
    int n_pass = 0;

    mdu_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_word(in_word), .in_src1(in_src1), .in_src2(in_src2),
        .in_tag(in_tag), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .mac_op(mac_op),
        .mac_src1(mac_src1), .mac_src2(mac_src2), .mac_result(mac_result), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // RV64M architectural result
    function automatic logic [63:0] ref_res(input logic [2:0] op, input bit w,
                                            input logic [63:0] s1, input logic [63:0] s2);
        logic [127:0]       p;
        logic [31:0]        r32;
        logic signed [31:0] sa32, sb32;
        logic signed [63:0] sa, sb;
        logic [63:0]        r;
        bit                 z32, o32, z64, o64;
        p = '0; r32 = '0; r = '0;
        sa32 = s1[31:0]; sb32 = s2[31:0]; sa = s1; sb = s2;
        z32 = (s2[31:0] == 32'd0);
        o32 = (s1[31:0] == 32'h8000_0000) && (s2[31:0] == 32'hFFFF_FFFF);
        z64 = (s2 == 64'd0);
        o64 = (s1 == 64'h8000_0000_0000_0000) && (s2 == '1);
        if (w && (op == 3'd0 || op[2])) begin
            case (op)
                3'd0: r32 = s1[31:0] * s2[31:0];
                3'd4: begin
                    if (z32) r32 = '1; else if (o32) r32 = s1[31:0]; else r32 = sa32 / sb32;
                end
                3'd5: begin if (z32) r32 = '1; else r32 = s1[31:0] / s2[31:0]; end
                3'd6: begin
                    if (z32) r32 = s1[31:0]; else if (o32) r32 = 32'd0; else r32 = sa32 % sb32;
                end
                3'd7: begin if (z32) r32 = s1[31:0]; else r32 = s1[31:0] % s2[31:0]; end
                default: r32 = 32'd0;
            endcase
            return {{32{r32[31]}}, r32};
        end
        case (op)
            3'd0: r = s1 * s2;
            3'd1: begin p = {{64{s1[63]}}, s1} * {{64{s2[63]}}, s2}; r = p[127:64]; end
            3'd2: begin p = {{64{s1[63]}}, s1} * {64'd0, s2};       r = p[127:64]; end
            3'd3: begin p = {64'd0, s1} * {64'd0, s2};              r = p[127:64]; end
            3'd4: begin if (z64) r = '1; else if (o64) r = s1; else r = sa / sb; end
            3'd5: begin if (z64) r = '1; else r = s1 / s2; end
            3'd6: begin if (z64) r = s1; else if (o64) r = 64'd0; else r = sa % sb; end
            default: begin if (z64) r = s1; else r = s1 % s2; end
        endcase
        return r;
    endfunction

    // Combinational arithmetic unit stand-in; undefined divisions give poison
    function automatic logic [63:0] mac_model(input logic [7:0] sel, input logic [63:0] a,
                                              input logic [63:0] b);
        logic [2:0] op;
        case (sel)
            8'h80: op = 3'd0;
            8'h40: op = 3'd1;
            8'h10: op = 3'd2;
            8'h20: op = 3'd3;
            8'h08: op = 3'd4;
            8'h04: op = 3'd5;
            8'h02: op = 3'd6;
            8'h01: op = 3'd7;
            default: return 64'h5A5A_5A5A_5A5A_5A5A;
        endcase
        if (op[2] && b == 64'd0) return 64'hBAD0_BAD0_BAD0_BAD0;
        if (op[2] && !op[0] && a == 64'h8000_0000_0000_0000 && b == '1) return 64'hBAD1_BAD1_BAD1_BAD1;
        return ref_res(op, 1'b0, a, b);
    endfunction

    always_comb mac_result = mac_model(mac_op, mac_src1, mac_src2);

    // Transaction-level model: one outstanding op, timed in cycles since accept
    logic [7:0]  onehot_tab [8] = '{8'h80, 8'h40, 8'h10, 8'h20, 8'h08, 8'h04, 8'h02, 8'h01};
    bit          m_busy, m_spec;
    int          m_t, m_lat, m_maclat;
    logic [63:0] m_res, m_src1, m_src2;
    logic [4:0]  m_tag;
    logic [7:0]  m_onehot;

    task automatic model_accept();
        bit w, zx;
        w  = in_word && (in_op == 3'd0 || in_op[2]);
        zx = (in_op == 3'd5 || in_op == 3'd7);
        m_spec = in_op[2] && ((w ? (in_src2[31:0] == 32'd0) : (in_src2 == 64'd0)) ||
                 (!in_op[0] && (w ? (in_src1[31:0] == 32'h8000_0000 && in_src2[31:0] == 32'hFFFF_FFFF)
                                  : (in_src1 == 64'h8000_0000_0000_0000 && in_src2 == '1))));
        m_maclat = in_op[2] ? DIV_LAT : MUL_LAT;
        m_lat    = (FAST && m_spec) ? 1 : m_maclat + 1;
        m_res    = ref_res(in_op, in_word, in_src1, in_src2);
        m_tag    = in_tag;
        m_onehot = onehot_tab[in_op];
        m_t      = 1;
        m_busy   = 1'b1;
        if (!m_spec) begin
            m_src1 = !w ? in_src1 : zx ? {32'd0, in_src1[31:0]} : {{32{in_src1[31]}}, in_src1[31:0]};
            m_src2 = !w ? in_src2 : zx ? {32'd0, in_src2[31:0]} : {{32{in_src2[31]}}, in_src2[31:0]};
        end
    endtask

    initial begin
        m_busy = 1'b0; m_spec = 1'b0; m_t = 0; m_lat = 1; m_maclat = 1;
        m_res = '0; m_src1 = '0; m_src2 = '0; m_tag = '0; m_onehot = '0;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                m_busy = 1'b0; m_src1 = '0; m_src2 = '0;
            end else if (flush) begin
                m_busy = 1'b0;
            end else if (m_busy) begin
                if (m_t >= m_lat) begin
                    if (out_ready) m_busy = 1'b0;
                end else m_t++;
            end else if (in_valid) begin
                model_accept();
            end
        end
    end

    // Per-cycle compare against the model
    initial begin
        logic       vld;
        logic [7:0] emac;
        forever begin
            @(negedge clock);
            if (!reset) begin
                vld  = m_busy && (m_t >= m_lat);
                emac = (m_busy && !m_spec && m_t <= m_maclat) ? m_onehot : 8'd0;
                chk("in_ready", 64'(in_ready), 64'(!m_busy && !flush));
                chk("busy", 64'(busy), 64'(m_busy));
                chk("out_valid", 64'(out_valid), 64'(vld));
                chk("mac_op", 64'(mac_op), 64'(emac));
                chk("mac_src1", mac_src1, m_src1);
                chk("mac_src2", mac_src2, m_src2);
                if (vld) begin
                    chk("out_result", out_result, m_res);
                    chk("out_tag", 64'(out_tag), 64'(m_tag));
                end
            end
        end
    end

    // Issue one op (DUT idle, called #1 after an edge); hold DONE for 'hold' cycles
    task automatic do_op(input logic [2:0] op, input bit w, input logic [63:0] s1,
                         input logic [63:0] s2, input logic [4:0] tag, input int hold,
                         output int lat, output int macc, output logic [63:0] res);
        in_op = op; in_word = w; in_src1 = s1; in_src2 = s2; in_tag = tag;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b0; lat = 1; macc = 0;
        while (!out_valid && lat < 200) begin
            if (mac_op != 8'd0) macc++;
            @(posedge clock); #1;
            lat++;
        end
        chk("result_arrives", 64'(out_valid), 64'd1);
        res = out_result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic issue_flush(input logic [2:0] op, input bit w, input logic [63:0] s1,
                               input logic [63:0] s2, input int d, input bit rdy);
        in_op = op; in_word = w; in_src1 = s1; in_src2 = s2; in_tag = 5'd9;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (d) begin @(posedge clock); #1; end
        flush = 1'b1; out_ready = rdy;
        @(posedge clock); #1;
        flush = 1'b0; out_ready = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h0000_0000_8000_0000;
            4: return 64'h0000_0000_FFFF_FFFF;
            5: return 64'($urandom_range(0, 9));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, macc;
        logic [63:0] res, s1, s2;
        logic [2:0] op;
        bit w;
        reset = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_word = 1'b0; in_src1 = '0;
        in_src2 = '0; in_tag = '0; flush = 1'b0; out_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mac_op", 64'(mac_op), 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1 chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clock); #1;

        // mul 3 * -4
        do_op(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 5'd3, 0, lat, macc, res);
        chk("mul_result", res, 64'hFFFF_FFFF_FFFF_FFF4);
        chk("mul_latency", 64'(lat), 64'd4);
        chk("mul_mac_cycles", 64'(macc), 64'd3);

        // divu by zero
        do_op(3'd5, 1'b0, 64'd7, 64'd0, 5'd4, 0, lat, macc, res);
        chk("divu0_result", res, '1);
        chk("divu0_latency", 64'(lat), FAST ? 64'd1 : 64'd17);
        chk("divu0_mac_cycles", 64'(macc), 64'd0);

        // divw / remw signed overflow
        do_op(3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd5, 0, lat, macc, res);
        chk("divw_ovf_result", res, 64'hFFFF_FFFF_8000_0000);
        do_op(3'd6, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd6, 0, lat, macc, res);
        chk("remw_ovf_result", res, 64'd0);

        // mulhu with a stalled consumer
        do_op(3'd3, 1'b0, '1, '1, 5'd7, 5, lat, macc, res);
        chk("mulhu_result", res, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("mulhu_after_stall", out_result, 64'hFFFF_FFFF_FFFF_FFFE);

        // flush in CALC cycle 5 of a div, then a mul right after
        issue_flush(3'd4, 1'b0, 64'd100, 64'd7, 4, 1'b0);
        do_op(3'd0, 1'b0, 64'd6, 64'd7, 5'd8, 0, lat, macc, res);
        chk("post_flush_mul", res, 64'd42);
        chk("post_flush_latency", 64'(lat), 64'd4);

        // reset mid-CALC of a rem
        in_op = 3'd6; in_word = 1'b0; in_src1 = 64'd1000; in_src2 = 64'd7; in_tag = 5'd11;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_mac_op", 64'(mac_op), 64'd0);
        chk("midrst_mac_src1", mac_src1, 64'd0);
        chk("midrst_mac_src2", mac_src2, 64'd0);
        chk("midrst_out_result", out_result, 64'd0);
        chk("midrst_out_tag", 64'(out_tag), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1 chk("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (20) @(posedge clock);
        #1;

        // randomized traffic
        for (int n = 0; n < 80; n++) begin
            op = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            s1 = pick();
            s2 = pick();
            if ($urandom_range(0, 5) == 0) begin
                issue_flush(op, w, s1, s2, int'($urandom_range(0, (op[2] ? DIV_LAT : MUL_LAT) + 2)),
                            1'($urandom_range(0, 1)));
            end else begin
                do_op(op, w, s1, s2, 5'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
                      lat, macc, res);
                chk("rand_result", res, ref_res(op, w, s1, s2));
            end
        end

        repeat (3) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
